data_cache: RTL and testbench
=============================

Name: data_cache

Overview:
- Direct-mapped, write-through, no-write-allocate data cache between the pipeline's MEM stage and the word-addressed data memory.
- Read hits are served combinationally in the same cycle.
- Read misses refill a whole line in multiple beats; writes are forwarded to memory.
- Asserts `stall` to freeze the pipeline while a miss or write is outstanding.

Parameters:
- LINES, 32, number of cache lines (power of two).
- WORDS, 4, 32-bit words per line (power of two).
- CNT_W, 16, width of hit/miss performance counters.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- cpu_adr  in  32  byte address from MEM stage; bits[1:0] ignored.
- cpu_wdata  in  32  store data.
- cpu_read  in  1  load request.
- cpu_write  in  1  store request.
- cpu_rdata  out  32  load data, valid when cpu_read && !stall.
- stall  out  1  freeze pipeline.
- mem_adr  out  32  backing-memory byte address.
- mem_wdata  out  32  backing-memory write data.
- mem_read  out  1  backing-memory read strobe.
- mem_write  out  1  backing-memory write strobe.
- mem_rdata  in  32  backing-memory read data.
- mem_ready  in  1  backing memory completed current beat.
- hit_count  out  CNT_W  saturating count of read hits.
- miss_count  out  CNT_W  saturating count of read misses.

Behaviour:
- Address split: offset = adr[log2(WORDS)+1:2], index = next log2(LINES) bits, tag = remaining upper bits.
- Reset (async) effects:
  - all valid bits cleared; FSM goes to IDLE; beat counter = 0; both counters = 0.
  - mem_read = mem_write = 0; mem_adr = mem_wdata = 0; stall = 0; cpu_rdata = 0.
  - Reset during REFILL or WRITE abandons the transaction; the partial line stays invalid.
- FSM states: IDLE, REFILL, WRITE.
- IDLE:
  - No request: stall = 0 and no memory strobes.
  - cpu_write (takes priority if cpu_read is also high): stall = 1; go to WRITE.
  - cpu_read hit (valid && tag match): cpu_rdata = line word[offset]; stall = 0; hit_count++ on the clock edge.
  - cpu_read miss: stall = 1; miss_count++; beat = 0; go to REFILL.
- REFILL:
  - stall = 1; mem_read = 1; mem_adr = {tag, index, beat, 2'b00}.
  - On mem_ready: write mem_rdata into word[beat]; beat++.
  - On mem_ready with beat == WORDS-1: set valid and tag for the line; go to IDLE.
  - The retried read then hits.
- WRITE:
  - mem_write = 1; mem_adr = cpu_adr with bits[1:0] zeroed; mem_wdata = cpu_wdata.
  - stall = !mem_ready.
  - On mem_ready: if the line hits, update word[offset] with cpu_wdata; go to IDLE. A write miss leaves the cache unchanged.
- Inputs are not latched. The stalled pipeline must hold cpu_* stable while stall = 1.
- mem_ready is ignored in IDLE.
- Latency with mem_ready tied high:
  - read hit: 0 stall cycles.
  - read miss: stall high exactly WORDS+1 cycles (5 with defaults); data is delivered in the following cycle.
  - store: stall high exactly 1 cycle.
- Each extra cycle mem_ready is low extends stall by 1 cycle.
- Counters saturate at all-ones and never wrap.
- A read of an address that was just written in the previous cycle must return the written value if the line was resident.

Decomposition:
- Shared package dcache_pkg:
  - state enum {IDLE, REFILL, WRITE}.
  - derived localparams OFF_W, IDX_W, TAG_W.
  - address field extraction functions.
- One sub-module, dcache_array, holds the storage:
  - valid/tag/data arrays with async-reset valid bits.
  - combinational read of {valid, tag, word}.
  - synchronous word write and tag/valid set ports.
- Top level keeps the FSM, beat counter, counters and mux logic.

Test Plan:
- Reset, then load from 0x40 with mem_ready=1 and memory word[0x40+4k] = 0x100+k → stall high 5 cycles; mem_adr steps 0x40, 0x44, 0x48, 0x4C; cpu_rdata = 0x100; miss_count = 1.
- Load 0x48 immediately after that refill → hit, stall = 0, cpu_rdata = 0x102, hit_count = 1.
- Store 0xDEADBEEF to 0x44 (resident) → stall 1 cycle; mem_write with mem_adr = 0x44; next load of 0x44 hits with 0xDEADBEEF.
- Store to 0x1000 (miss) then load 0x1000 → store does not allocate; load misses (miss_count++) and refills from memory.
- Load 0x40 then load conflicting 0x40+LINES*WORDS*4 → second load evicts; reload of 0x40 misses again.
- mem_ready low for 3 cycles on beat 2, then assert rst mid-REFILL → stall extends by 3 cycles before reset; after reset all outputs are 0; reload of 0x40 misses.

Source files
------------

// File: rtl/dcache_pkg.sv
// Shared types, default geometry and address-field helpers for the
// direct-mapped write-through data cache.
package dcache_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      REFILL = 2'd1,
      WRITE  = 2'd2
   } state_t;

   localparam int DEF_LINES = 32;
   localparam int DEF_WORDS = 4;
   localparam int OFF_W     = $clog2(DEF_WORDS);
   localparam int IDX_W     = $clog2(DEF_LINES);
   localparam int TAG_W     = 30 - OFF_W - IDX_W;

   // Field extractors return zero-extended fields; callers size-cast to width.
   function automatic logic [31:0] adr_offset(input logic [31:0] adr, input int off_w);
      return (adr >> 2) & ((32'd1 << off_w) - 32'd1);
   endfunction

   function automatic logic [31:0] adr_index(input logic [31:0] adr, input int off_w,
                                             input int idx_w);
      return (adr >> (off_w + 2)) & ((32'd1 << idx_w) - 32'd1);
   endfunction

   function automatic logic [31:0] adr_tag(input logic [31:0] adr, input int off_w,
                                           input int idx_w);
      return adr >> (off_w + idx_w + 2);
   endfunction

endpackage

// File: rtl/dcache_array.sv
// Valid/tag/data storage for the data cache: combinational read of the indexed
// line, synchronous word write and tag/valid update.
module dcache_array
   import dcache_pkg::*;
#(
   parameter int LINES    = DEF_LINES,
   parameter int WORDS    = DEF_WORDS,
   parameter int OFF_BITS = OFF_W,
   parameter int IDX_BITS = IDX_W,
   parameter int TAG_BITS = TAG_W
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [IDX_BITS-1:0] index,
   input  logic [OFF_BITS-1:0] rd_offset,
   output logic                rd_valid,
   output logic [TAG_BITS-1:0] rd_tag,
   output logic [31:0]         rd_word,
   input  logic                wr_en,
   input  logic [OFF_BITS-1:0] wr_offset,
   input  logic [31:0]         wr_data,
   input  logic                set_en,
   input  logic                set_valid,
   input  logic [TAG_BITS-1:0] set_tag
);

   logic [31:0]         data_r [0:LINES*WORDS-1];
   logic [TAG_BITS-1:0] tag_r  [0:LINES-1];
   logic [LINES-1:0]    valid_r;

   assign rd_valid = valid_r[index];
   assign rd_tag   = tag_r[index];
   assign rd_word  = data_r[{index, rd_offset}];

   // Data and tag RAMs carry no reset; the valid bits guard them.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         data_r[{index, wr_offset}] <= wr_data;
      end
      if (set_en) begin
         tag_r[index] <= set_tag;
      end
   end

   // Valid bits: cleared on reset, written through the tag/valid set port.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         valid_r <= {LINES{1'b0}};
      end else if (set_en) begin
         valid_r[index] <= set_valid;
      end
   end

endmodule

// File: rtl/data_cache.sv
// Direct-mapped, write-through, no-write-allocate data cache. Read hits are
// served in the same cycle; misses refill a whole line, stores go to memory.
module data_cache
   import dcache_pkg::*;
#(
   parameter int LINES = DEF_LINES,
   parameter int WORDS = DEF_WORDS,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [31:0]      cpu_adr,
   input  logic [31:0]      cpu_wdata,
   input  logic             cpu_read,
   input  logic             cpu_write,
   output logic [31:0]      cpu_rdata,
   output logic             stall,
   output logic [31:0]      mem_adr,
   output logic [31:0]      mem_wdata,
   output logic             mem_read,
   output logic             mem_write,
   input  logic [31:0]      mem_rdata,
   input  logic             mem_ready,
   output logic [CNT_W-1:0] hit_count,
   output logic [CNT_W-1:0] miss_count
);

   localparam int OFF_BITS = $clog2(WORDS);
   localparam int IDX_BITS = $clog2(LINES);
   localparam int TAG_BITS = 30 - OFF_BITS - IDX_BITS;
   localparam logic [OFF_BITS-1:0] LAST_BEAT = OFF_BITS'(WORDS - 1);

   state_t              state_r, state_nx_s;
   logic [OFF_BITS-1:0] beat_r;
   logic [CNT_W-1:0]    hit_count_r, miss_count_r;

   logic [OFF_BITS-1:0] offset_s;
   logic [IDX_BITS-1:0] index_s;
   logic [TAG_BITS-1:0] tag_s;
   logic                rd_valid_s;
   logic [TAG_BITS-1:0] rd_tag_s;
   logic [31:0]         rd_word_s;
   logic                hit_s;

   logic                wr_en_s, set_en_s, set_valid_s;
   logic [OFF_BITS-1:0] wr_offset_s;
   logic [31:0]         wr_data_s;
   logic                hit_inc_s, miss_inc_s, beat_clr_s, beat_inc_s;

   assign offset_s = OFF_BITS'(adr_offset(cpu_adr, OFF_BITS));
   assign index_s  = IDX_BITS'(adr_index(cpu_adr, OFF_BITS, IDX_BITS));
   assign tag_s    = TAG_BITS'(adr_tag(cpu_adr, OFF_BITS, IDX_BITS));
   assign hit_s    = rd_valid_s && (rd_tag_s == tag_s);

   dcache_array #(
      .LINES    (LINES),
      .WORDS    (WORDS),
      .OFF_BITS (OFF_BITS),
      .IDX_BITS (IDX_BITS),
      .TAG_BITS (TAG_BITS)
   ) u_array (
      .clk       (clk),
      .rst       (rst),
      .index     (index_s),
      .rd_offset (offset_s),
      .rd_valid  (rd_valid_s),
      .rd_tag    (rd_tag_s),
      .rd_word   (rd_word_s),
      .wr_en     (wr_en_s),
      .wr_offset (wr_offset_s),
      .wr_data   (wr_data_s),
      .set_en    (set_en_s),
      .set_valid (set_valid_s),
      .set_tag   (tag_s)
   );

   // FSM state register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_nx_s;
      end
   end

   // FSM next-state logic; a store wins over a simultaneous load.
   always_comb begin
      state_nx_s = state_r;
      case (state_r)
         IDLE: begin
            if (cpu_write) begin
               state_nx_s = WRITE;
            end else if (cpu_read && !hit_s) begin
               state_nx_s = REFILL;
            end else begin
               state_nx_s = IDLE;
            end
         end
         REFILL: begin
            if (mem_ready && (beat_r == LAST_BEAT)) begin
               state_nx_s = IDLE;
            end else begin
               state_nx_s = REFILL;
            end
         end
         WRITE: begin
            if (mem_ready) begin
               state_nx_s = IDLE;
            end else begin
               state_nx_s = WRITE;
            end
         end
         default: state_nx_s = IDLE;
      endcase
   end

   // FSM outputs: pipeline handshake, memory strobes and array write controls.
   always_comb begin
      cpu_rdata   = 32'd0;
      stall       = 1'b0;
      mem_adr     = 32'd0;
      mem_wdata   = 32'd0;
      mem_read    = 1'b0;
      mem_write   = 1'b0;
      wr_en_s     = 1'b0;
      wr_offset_s = offset_s;
      wr_data_s   = cpu_wdata;
      set_en_s    = 1'b0;
      set_valid_s = 1'b0;
      hit_inc_s   = 1'b0;
      miss_inc_s  = 1'b0;
      beat_clr_s  = 1'b0;
      beat_inc_s  = 1'b0;
      case (state_r)
         IDLE: begin
            if (cpu_write) begin
               stall = 1'b1;
            end else if (cpu_read && hit_s) begin
               cpu_rdata = rd_word_s;
               hit_inc_s = 1'b1;
            end else if (cpu_read) begin
               // Drop the victim's valid bit before its words get overwritten.
               stall       = 1'b1;
               miss_inc_s  = 1'b1;
               beat_clr_s  = 1'b1;
               set_en_s    = 1'b1;
               set_valid_s = 1'b0;
            end else begin
               stall = 1'b0;
            end
         end
         REFILL: begin
            stall       = 1'b1;
            mem_read    = 1'b1;
            mem_adr     = {tag_s, index_s, beat_r, 2'b00};
            wr_en_s     = mem_ready;
            wr_offset_s = beat_r;
            wr_data_s   = mem_rdata;
            beat_inc_s  = mem_ready;
            set_en_s    = mem_ready && (beat_r == LAST_BEAT);
            set_valid_s = 1'b1;
         end
         WRITE: begin
            stall     = !mem_ready;
            mem_write = 1'b1;
            mem_adr   = {cpu_adr[31:2], 2'b00};
            mem_wdata = cpu_wdata;
            wr_en_s   = mem_ready && hit_s;
         end
         default: begin
            stall = 1'b0;
         end
      endcase
   end

   // Refill beat counter.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         beat_r <= {OFF_BITS{1'b0}};
      end else if (beat_clr_s) begin
         beat_r <= {OFF_BITS{1'b0}};
      end else if (beat_inc_s) begin
         beat_r <= beat_r + OFF_BITS'(1);
      end else begin
         beat_r <= beat_r;
      end
   end

   // Saturating hit/miss performance counters.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         hit_count_r  <= {CNT_W{1'b0}};
         miss_count_r <= {CNT_W{1'b0}};
      end else begin
         if (hit_inc_s && (hit_count_r != {CNT_W{1'b1}})) begin
            hit_count_r <= hit_count_r + CNT_W'(1);
         end
         if (miss_inc_s && (miss_count_r != {CNT_W{1'b1}})) begin
            miss_count_r <= miss_count_r + CNT_W'(1);
         end
      end
   end

   assign hit_count  = hit_count_r;
   assign miss_count = miss_count_r;

endmodule

// File: tb/tb_data_cache.sv
// Scoreboard bench for data_cache: directed loads/stores push expected load
// data, refill beat addresses and store beats; a negedge monitor compares them.
module tb_data_cache;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] cpu_adr, cpu_wdata, cpu_rdata;
   logic        cpu_read, cpu_write, stall;
   logic [31:0] mem_adr, mem_wdata, mem_rdata;
   logic        mem_read, mem_write, mem_ready;
   logic [15:0] hit_count, miss_count;

   typedef struct {
      logic [31:0] adr;
      logic [31:0] data;
   } wr_t;

   logic [31:0] rd_q[$];
   logic [31:0] ra_q[$];
   wr_t         wr_q[$];
   int          checks = 0;
   int          errors = 0;
   logic [31:0] tb_mem [0:2047];

   data_cache #(.LINES(32), .WORDS(4), .CNT_W(16)) dut (
      .clk        (clk),
      .rst        (rst),
      .cpu_adr    (cpu_adr),
      .cpu_wdata  (cpu_wdata),
      .cpu_read   (cpu_read),
      .cpu_write  (cpu_write),
      .cpu_rdata  (cpu_rdata),
      .stall      (stall),
      .mem_adr    (mem_adr),
      .mem_wdata  (mem_wdata),
      .mem_read   (mem_read),
      .mem_write  (mem_write),
      .mem_rdata  (mem_rdata),
      .mem_ready  (mem_ready),
      .hit_count  (hit_count),
      .miss_count (miss_count)
   );

   always #5 clk = ~clk;

   // Backing memory: word at byte address a holds 0x100 + (a - 0x40)/4 after reset.
   assign mem_rdata = tb_mem[mem_adr[12:2]];
   always @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < 2048; i++) tb_mem[i] <= 32'h100 + 32'(i) - 32'h10;
      end else if (mem_write && mem_ready) begin
         tb_mem[mem_adr[12:2]] <= mem_wdata;
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic unexpected(input string name, input logic [31:0] act);
      checks++;
      errors++;
      $display("FAIL %s: got 0x%08h expected nothing", name, act);
   endtask

   // Monitor: pops the scoreboard whenever the DUT presents data or a memory beat.
   always @(negedge clk) begin
      if (!rst) begin
         if (cpu_read && !cpu_write && !stall) begin
            if (rd_q.size() == 0) unexpected("unexpected_load_data", cpu_rdata);
            else check("load_data", cpu_rdata, rd_q.pop_front());
         end
         if (mem_read && mem_ready) begin
            if (ra_q.size() == 0) unexpected("unexpected_refill_beat", mem_adr);
            else check("refill_adr", mem_adr, ra_q.pop_front());
         end
         if (mem_write && mem_ready) begin
            if (wr_q.size() == 0) begin
               unexpected("unexpected_store_beat", mem_adr);
            end else begin
               wr_t w;
               w = wr_q.pop_front();
               check("store_adr", mem_adr, w.adr);
               check("store_data", mem_wdata, w.data);
            end
         end
      end
   end

   task automatic do_load(input logic [31:0] adr, input logic [31:0] exp_data,
                          input int exp_stall, input bit miss);
      int n;
      n = 0;
      if (miss) begin
         for (int k = 0; k < 4; k++) ra_q.push_back((adr & 32'hFFFF_FFF0) + 32'(4 * k));
      end
      rd_q.push_back(exp_data);
      cpu_adr  = adr;
      cpu_read = 1'b1;
      @(negedge clk);
      while (stall && n < 40) begin
         n++;
         @(negedge clk);
      end
      check("load_stall_cycles", 32'(n), 32'(exp_stall));
      @(posedge clk);
      #1;
      cpu_read = 1'b0;
   endtask

   task automatic do_store(input logic [31:0] adr, input logic [31:0] data);
      int n;
      wr_t w;
      n = 0;
      w.adr  = adr & 32'hFFFF_FFFC;
      w.data = data;
      wr_q.push_back(w);
      cpu_adr   = adr;
      cpu_wdata = data;
      cpu_write = 1'b1;
      @(negedge clk);
      while (stall && n < 40) begin
         n++;
         @(negedge clk);
      end
      check("store_stall_cycles", 32'(n), 32'd1);
      @(posedge clk);
      #1;
      cpu_write = 1'b0;
   endtask

   task automatic check_counts(input int hits, input int misses);
      check("hit_count", 32'(hit_count), 32'(hits));
      check("miss_count", 32'(miss_count), 32'(misses));
   endtask

   task automatic check_idle_outputs();
      check("rst_stall", 32'(stall), 32'd0);
      check("rst_cpu_rdata", cpu_rdata, 32'd0);
      check("rst_mem_read", 32'(mem_read), 32'd0);
      check("rst_mem_write", 32'(mem_write), 32'd0);
      check("rst_mem_adr", mem_adr, 32'd0);
      check("rst_mem_wdata", mem_wdata, 32'd0);
      check_counts(0, 0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1);
   end

   initial begin
      int n;
      rst       = 1'b1;
      cpu_adr   = 32'd0;
      cpu_wdata = 32'd0;
      cpu_read  = 1'b0;
      cpu_write = 1'b0;
      mem_ready = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check_idle_outputs();
      @(posedge clk);
      #1;
      rst = 1'b0;

      // Cold miss: 5 stall cycles, beats 0x40..0x4C, retried read hits.
      do_load(32'h40, 32'h100, 5, 1'b1);
      check_counts(1, 1);
      do_load(32'h48, 32'h102, 0, 1'b0);
      check_counts(2, 1);

      // Write-through hit updates the line; the next load sees it.
      do_store(32'h44, 32'hDEAD_BEEF);
      do_load(32'h44, 32'hDEAD_BEEF, 0, 1'b0);
      check_counts(3, 1);

      // Store miss does not allocate; the load refills the stored value.
      do_store(32'h1000, 32'hCAFE_F00D);
      check_counts(3, 1);
      do_load(32'h1000, 32'hCAFE_F00D, 5, 1'b1);
      check_counts(4, 2);

      // Conflict on index 4: 0x240 evicts 0x40, which then misses again.
      do_load(32'h40, 32'h100, 0, 1'b0);
      do_load(32'h240, 32'h180, 5, 1'b1);
      do_load(32'h40, 32'h100, 5, 1'b1);
      check_counts(7, 4);

      // mem_ready low for 3 cycles on beat 2, then reset mid-refill.
      ra_q.push_back(32'h240);
      ra_q.push_back(32'h244);
      cpu_adr  = 32'h240;
      cpu_read = 1'b1;
      n = 0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         if (stall) n++;
         if (i == 2) begin
            @(posedge clk);
            #1;
            mem_ready = 1'b0;
         end
      end
      check("stretched_stall_cycles", 32'(n), 32'd6);
      check("stuck_beat_adr", mem_adr, 32'h248);
      check("stuck_mem_read", 32'(mem_read), 32'd1);
      check("stuck_miss_count", 32'(miss_count), 32'd5);
      check("refill_beats_consumed", 32'(ra_q.size()), 32'd0);
      rst      = 1'b1;
      cpu_read = 1'b0;
      #1;
      check_idle_outputs();
      @(posedge clk);
      #1;
      rst       = 1'b0;
      mem_ready = 1'b1;
      do_load(32'h40, 32'h100, 5, 1'b1);
      check_counts(1, 1);

      repeat (2) @(negedge clk);
      check("load_queue_drained", 32'(rd_q.size()), 32'd0);
      check("refill_queue_drained", 32'(ra_q.size()), 32'd0);
      check("store_queue_drained", 32'(wr_q.size()), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
